// File: rtl/uart_tx_fifo_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_reader_if
// Purpose  : FIFO read-port bundle between a FIFO and the UART TX reader.
//            master = reader (issues fifo_rd), slave = FIFO (returns data).
// Signals  : fifo_empty   - FIFO empty flag, read-clock domain
//            fifo_rd_data - read data, valid 1 clk after the fifo_rd cycle
//            fifo_rd      - 1-cycle read command per byte
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_fifo_reader_if;
    logic       fifo_empty;
    logic [7:0] fifo_rd_data;
    logic       fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        input  fifo_rd
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo_reader
// Purpose  : Pulls bytes from a FIFO read port and serializes each onto the
//            UART line: start bit, DATA_BITS data bits LSB first, optional
//            parity bit, STOP_BITS stop bits.
// Ports    : clk     - single clock (FIFO read clock)
//            reset   - synchronous, active-high
//            fifo    - FIFO read port (master side)
//            tx      - serial output, idle high
//            tx_busy - high from the fifo_rd cycle through the last stop cycle
//            tx_done - 1-cycle pulse on the last clk of the final stop bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_reader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    uart_tx_fifo_reader_if.master        fifo,
    output logic                         tx,
    output logic                         tx_busy,
    output logic                         tx_done
);

    localparam int                    c_timer_w    = $clog2(CLKS_PER_BIT);
    localparam logic [c_timer_w-1:0]  c_last_tick  = c_timer_w'(CLKS_PER_BIT - 1);
    // tx_done is a flop, so it is loaded one cycle before the final stop clock.
    localparam logic [c_timer_w-1:0]  c_done_tick  = c_timer_w'(CLKS_PER_BIT - 2);
    localparam logic [3:0]            c_data_last  = 4'(DATA_BITS - 1);
    localparam logic [3:0]            c_stop_last  = 4'(STOP_BITS - 1);
    localparam logic                  c_parity_odd = (PARITY_ODD != 0);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_fetch  = 3'd1;
    localparam logic [2:0] c_st_start  = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_parity = 3'd4;
    localparam logic [2:0] c_st_stop   = 3'd5;

    logic [2:0]           r_state;
    logic [c_timer_w-1:0] r_timer;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_fifo_rd;
    logic                 r_busy;
    logic                 r_done;

    logic [7:0]           w_rd_data;
    logic                 w_tick;

    assign w_rd_data = fifo.fifo_rd_data;
    assign w_tick    = (r_timer == c_last_tick);

    // Upper read-data bits are deliberately ignored for narrow frames.
    if (DATA_BITS < 8) begin : g_unused_hi
        logic w_unused_hi;
        assign w_unused_hi = ^w_rd_data[7:DATA_BITS];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_timer   <= '0;
            r_bit_cnt <= '0;
            r_shreg   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
            r_fifo_rd <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_fifo_rd <= 1'b0;
            r_done    <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_tx      <= 1'b1;
                    r_timer   <= '0;
                    r_bit_cnt <= '0;
                    // The cycle with fifo_rd high is the IDLE cycle itself;
                    // the flag is sampled one edge earlier, which is safe
                    // because only this block can make the FIFO empty.
                    if (r_fifo_rd) begin
                        r_state <= c_st_fetch;
                    end else if (!fifo.fifo_empty) begin
                        r_fifo_rd <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end

                c_st_fetch: begin
                    r_shreg  <= w_rd_data[DATA_BITS-1:0];
                    r_parity <= (^w_rd_data[DATA_BITS-1:0]) ^ c_parity_odd;
                    r_tx     <= 1'b0;
                    r_timer  <= '0;
                    r_state  <= c_st_start;
                end

                c_st_start: begin
                    if (w_tick) begin
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                        r_tx      <= r_shreg[0];
                        r_state   <= c_st_data;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                c_st_data: begin
                    if (w_tick) begin
                        r_timer <= '0;
                        r_shreg <= r_shreg >> 1;
                        if (r_bit_cnt == c_data_last) begin
                            r_bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                r_tx    <= r_parity;
                                r_state <= c_st_parity;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= c_st_stop;
                            end
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            // tx is registered: present the next bit now.
                            r_tx      <= r_shreg[1];
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                c_st_parity: begin
                    if (w_tick) begin
                        r_timer   <= '0;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= c_st_stop;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                c_st_stop: begin
                    r_tx <= 1'b1;
                    if (r_bit_cnt == c_stop_last && r_timer == c_done_tick) begin
                        r_done <= 1'b1;
                    end
                    if (w_tick) begin
                        r_timer <= '0;
                        if (r_bit_cnt == c_stop_last) begin
                            r_bit_cnt <= '0;
                            r_state   <= c_st_idle;
                            // Issue the next read so that it lands in the
                            // first IDLE cycle, keeping the gap at 2 cycles.
                            r_fifo_rd <= !fifo.fifo_empty;
                            r_busy    <= !fifo.fifo_empty;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fifo.fifo_rd = r_fifo_rd;
    assign tx           = r_tx;
    assign tx_busy      = r_busy;
    assign tx_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo_reader
// Purpose  : Self-checking bench for uart_tx_fifo_reader. Five frame formats
//            run side by side, each fed by a FIFO model with random bytes and
//            compared every cycle against a frame-level reference waveform.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_reader;

    localparam int c_n_cfg = 5;

    function automatic int cfg_cpb(input int k);
        return (k == 4) ? 2 : 4;
    endfunction
    function automatic int cfg_db(input int k);
        return (k == 3) ? 7 : ((k == 4) ? 5 : 8);
    endfunction
    function automatic int cfg_pen(input int k);
        return (k == 1 || k == 2 || k == 4) ? 1 : 0;
    endfunction
    function automatic int cfg_podd(input int k);
        return (k == 2 || k == 4) ? 1 : 0;
    endfunction
    function automatic int cfg_sb(input int k);
        return (k == 3 || k == 4) ? 2 : 1;
    endfunction

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic feed      = 1'b0;
    logic final_chk = 1'b0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    for (genvar k = 0; k < c_n_cfg; k++) begin : g_cfg
        localparam int CPB       = cfg_cpb(k);
        localparam int DB        = cfg_db(k);
        localparam int PEN       = cfg_pen(k);
        localparam int PODD      = cfg_podd(k);
        localparam int SB        = cfg_sb(k);
        localparam int FRAME_LEN = 2 + (1 + DB + PEN + SB) * CPB;

        uart_tx_fifo_reader_if u_if ();
        logic tx;
        logic tx_busy;
        logic tx_done;

        uart_tx_fifo_reader #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (DB),
            .PARITY_EN    (PEN),
            .PARITY_ODD   (PODD),
            .STOP_BITS    (SB)
        ) u_dut (
            .clk     (clk),
            .reset   (rst),
            .fifo    (u_if.master),
            .tx      (tx),
            .tx_busy (tx_busy),
            .tx_done (tx_done)
        );

        logic [7:0]  q[$];
        logic        r_empty   = 1'b1;
        logic [7:0]  r_rd_data = 8'h00;
        logic        r_loaded  = 1'b0;
        int          pos       = -1;     // cycle index within the current frame
        logic [15:0] frame_bits;         // frame bit i goes out i-th (start first)
        logic [3:0]  r_exp     = 4'b1000; // {tx, fifo_rd, tx_busy, tx_done}

        assign u_if.fifo_empty   = r_empty;
        assign u_if.fifo_rd_data = r_rd_data;

        always @(posedge clk) begin : p_model
            logic [7:0] b;
            if (!r_loaded) begin
                case (k)
                    0:       q = '{8'hA5, 8'h00, 8'hFF, 8'h3C};
                    1, 2:    q = '{8'h07};
                    3:       q = '{8'hC1};
                    default: q = '{8'h2B};
                endcase
                r_loaded = 1'b1;
            end

            // FIFO: registered read, data valid for one cycle after fifo_rd.
            if (u_if.fifo_rd && q.size() != 0) r_rd_data <= q.pop_front();
            else                               r_rd_data <= 8'($urandom);

            // Reference: a frame is 2 high cycles then bits of CPB cycles each.
            if (rst) begin
                pos = -1;
            end else if (pos >= 0 && pos < FRAME_LEN - 1) begin
                pos++;
            end else if (!r_empty) begin
                pos = 0;
                b = (q.size() != 0) ? q[0] : 8'h00;
                frame_bits = '1;
                frame_bits[0] = 1'b0;
                for (int i = 0; i < DB; i++) frame_bits[1 + i] = b[i];
                if (PEN != 0) begin
                    frame_bits[1 + DB] = 1'b0;
                    for (int i = 0; i < DB; i++) frame_bits[1 + DB] ^= b[i];
                    frame_bits[1 + DB] ^= (PODD != 0);
                end
            end else begin
                pos = -1;
            end

            if (pos < 0)       r_exp = 4'b1000;
            else if (pos == 0) r_exp = 4'b1110;
            else if (pos == 1) r_exp = 4'b1010;
            else               r_exp = {frame_bits[(pos - 2) / CPB], 1'b0, 1'b1,
                                        (pos == FRAME_LEN - 1)};

            if (feed && q.size() < 6 && $urandom_range(0, 99) < 3)
                q.push_back(8'($urandom));
            r_empty <= (q.size() == 0);
        end

        always @(negedge clk) begin
            if (r_loaded)
                check($sformatf("cfg%0d {tx,rd,busy,done}", k),
                      {28'd0, tx, u_if.fifo_rd, tx_busy, tx_done}, {28'd0, r_exp});
            if (final_chk) begin
                check($sformatf("cfg%0d fifo drained", k), q.size(), 0);
                check($sformatf("cfg%0d busy after drain", k), {31'd0, tx_busy}, 0);
            end
        end
    end

    initial begin
        int budget;
        rst  = 1'b1;
        feed = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        // Preloaded bytes go out back to back.
        repeat (220) @(negedge clk);
        feed = 1'b1;
        repeat (1500) @(negedge clk);

        // Reset in the middle of data bit 3 of a cfg0 frame.
        budget = 0;
        while (g_cfg[0].pos != 2 + 4 * 4 + 1 && budget < 3000) begin
            @(negedge clk);
            budget++;
        end
        check("cfg0 reached data bit 3", {31'd0, budget < 3000}, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        repeat (1500) @(negedge clk);
        feed = 1'b0;
        repeat (1500) @(negedge clk);

        @(posedge clk);
        #1 final_chk = 1'b1;
        @(posedge clk);
        #1 final_chk = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
